// File: rtl/tdm_pkg.sv
// Shared types and constants for the 1x8 TDM demultiplexer.
// Optional feature macro used by the top: TDM_SYNC_ERR_EN.
package tdm_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } tdm_state_e;

   localparam int N_SLOT         = 8;
   localparam int SLOT_W         = 3;
   localparam int SYNC_ERR_LIMIT = 3;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: clear to 0, load 1 on a sync-aligned sample, or advance
// by one with natural wrap 7 -> 0.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              load1_i,
   input  logic              inc_i,
   output logic [SLOT_W-1:0] slot_o
);

   logic [SLOT_W-1:0] slot_q;
   logic [SLOT_W-1:0] slot_d;

   // next slot value; clear has priority over load, load over advance
   always_comb begin
      slot_d = slot_q;
      if (clr_i)
         slot_d = '0;
      else if (load1_i)
         slot_d = SLOT_W'(1);
      else if (inc_i)
         slot_d = slot_q + SLOT_W'(1);
   end

   // slot register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         slot_q <= '0;
      else
         slot_q <= slot_d;
   end

   assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux_1x8.sv
// 1x8 TDM demultiplexer with sync-based frame alignment.
// Macro TDM_SYNC_ERR_EN: adds sync_err pulses and a misaligned-sync counter
// that drops back to HUNT after SYNC_ERR_LIMIT realignments without a frame.
//
// state | meaning
// HUNT  | no frame alignment, waiting for sync with en
// LOCK  | aligned, capturing one bit per en strobe into the shadow register
module tdm_demux_1x8
   import tdm_pkg::*;
#(
   parameter logic [N_SLOT-1:0] RESET_VAL = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din,
   input  logic              en,
   input  logic              sync,
   output logic [N_SLOT-1:0] y,
   output logic [SLOT_W-1:0] slot,
   output logic              locked,
   output logic              frame_valid,
   output logic              sync_err
);

   tdm_state_e        state_q, state_d;
   logic [N_SLOT-1:0] shadow_q, shadow_d;
   logic [N_SLOT-1:0] y_q, y_d;
   logic              fv_q, fv_d;
   logic              se_d;
   logic              ctr_clr, ctr_load1, ctr_inc;
   logic [SLOT_W-1:0] slot_w;

`ifdef TDM_SYNC_ERR_EN
   logic [1:0] errcnt_q, errcnt_d;
   logic       se_q;
`endif

   tdm_slot_ctr u_slot_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (ctr_clr),
      .load1_i (ctr_load1),
      .inc_i   (ctr_inc),
      .slot_o  (slot_w)
   );

   // next-state, shadow capture, frame output and pulse generation
   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      y_d       = y_q;
      fv_d      = 1'b0;
      se_d      = 1'b0;
      ctr_clr   = 1'b0;
      ctr_load1 = 1'b0;
      ctr_inc   = 1'b0;
`ifdef TDM_SYNC_ERR_EN
      errcnt_d  = errcnt_q;
`endif
      if (en) begin
         unique case (state_q)
            HUNT: begin
               if (sync) begin
                  shadow_d  = {{(N_SLOT-1){1'b0}}, din};
                  ctr_load1 = 1'b1;
                  state_d   = LOCK;
               end
            end
            LOCK: begin
               if (sync && (slot_w != '0)) begin
                  // misaligned sync: drop the partial frame, this bit is slot 0
                  se_d = 1'b1;
`ifdef TDM_SYNC_ERR_EN
                  if (errcnt_q == 2'(SYNC_ERR_LIMIT - 1)) begin
                     state_d  = HUNT;
                     shadow_d = '0;
                     ctr_clr  = 1'b1;
                     errcnt_d = '0;
                  end else begin
                     shadow_d  = {{(N_SLOT-1){1'b0}}, din};
                     ctr_load1 = 1'b1;
                     errcnt_d  = errcnt_q + 2'd1;
                  end
`else
                  shadow_d  = {{(N_SLOT-1){1'b0}}, din};
                  ctr_load1 = 1'b1;
`endif
               end else begin
                  shadow_d[slot_w] = din;
                  ctr_inc          = 1'b1;
                  if (slot_w == SLOT_W'(N_SLOT - 1)) begin
                     y_d  = shadow_d;
                     fv_d = 1'b1;
`ifdef TDM_SYNC_ERR_EN
                     errcnt_d = '0;
`endif
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= HUNT;
         shadow_q <= '0;
         y_q      <= RESET_VAL;
         fv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         y_q      <= y_d;
         fv_q     <= fv_d;
      end
   end

`ifdef TDM_SYNC_ERR_EN
   // misaligned-sync counter and error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         errcnt_q <= '0;
         se_q     <= 1'b0;
      end else begin
         errcnt_q <= errcnt_d;
         se_q     <= se_d;
      end
   end

   assign sync_err = se_q;
`else
   // realignment still happens, but is not reported
   assign sync_err = 1'b0;
   logic unused_se;
   assign unused_se = se_d;
`endif

   assign y           = y_q;
   assign slot        = slot_w;
   assign locked      = (state_q == LOCK);
   assign frame_valid = fv_q;

endmodule
